exe_mem_stage_reg: RTL and testbench

//  EXE->MEM pipeline register plus CPSR-style status register, directly downstream of the ALU.

---
 rtl/exe_mem_stage_reg.sv | 127 ++++++++++++
 tb/tb_exe_mem_stage_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// exe_mem_stage_reg
//
// EXE->MEM pipeline register with an attached CPSR-style status register.
// Sits directly behind the ALU. Each rising edge it captures the ALU result,
// store data, destination index and control bits. On S-bit instructions it
// also updates the {N,Z,C,V} flags. The registered carry goes back to the ALU
// through c_out. It also counts the instructions accepted into MEM.
//
// Parameters
//   DW     data/address width
//   RW     register-file index width
//   CNT_W  retired-instruction counter width
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   freeze            hold every register (stage stall)
//   kill              squash the current EXE instruction (bubble)
//   valid_in          EXE holds a real instruction
//   wb_en_in, mem_r_en_in, mem_w_en_in   control bits to forward
//   s_in, cv_upd_in   flag-update request / C,V valid for this op
//   alu_res_in, sr_in, st_val_in, dest_in   datapath values
//   valid_out, wb_en_out, mem_r_en_out, mem_w_en_out   gated control
//   alu_res_out, st_val_out, dest_out       registered datapath
//   status_reg        architectural flags {N,Z,C,V}
//   c_out             registered carry flag for the ALU
//   retired_cnt       count of accepted instructions (wraps)
//
// Every output comes straight from a flop. There is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module exe_mem_stage_reg #(
   parameter int DW    = 32,
   parameter int RW    = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             kill,
   input  logic             valid_in,
   input  logic             wb_en_in,
   input  logic             mem_r_en_in,
   input  logic             mem_w_en_in,
   input  logic             s_in,
   input  logic             cv_upd_in,
   input  logic [DW-1:0]    alu_res_in,
   input  logic [3:0]       sr_in,
   input  logic [DW-1:0]    st_val_in,
   input  logic [RW-1:0]    dest_in,
   output logic             valid_out,
   output logic             wb_en_out,
   output logic             mem_r_en_out,
   output logic             mem_w_en_out,
   output logic [DW-1:0]    alu_res_out,
   output logic [DW-1:0]    st_val_out,
   output logic [RW-1:0]    dest_out,
   output logic [3:0]       status_reg,
   output logic             c_out,
   output logic [CNT_W-1:0] retired_cnt
);

   logic       accept_s;
   logic [3:0] status_next_s;

   // Decide whether the instruction enters MEM, and compute the next flag value
   always_comb begin
      accept_s      = valid_in & ~kill & ~freeze;
      status_next_s = status_reg;
      if (accept_s && s_in) begin
         if (cv_upd_in) begin
            status_next_s = sr_in;
         end else begin
            // Logic/MOV ops update only N and Z. C and V keep their architectural values.
            status_next_s = {sr_in[3], sr_in[2], status_reg[1], status_reg[0]};
         end
      end else begin
         status_next_s = status_reg;
      end
   end

   // Pipeline, status and counter registers: rst > freeze > normal (kill folded into accept)
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out    <= 1'b0;
         wb_en_out    <= 1'b0;
         mem_r_en_out <= 1'b0;
         mem_w_en_out <= 1'b0;
         alu_res_out  <= {DW{1'b0}};
         st_val_out   <= {DW{1'b0}};
         dest_out     <= {RW{1'b0}};
         status_reg   <= 4'b0000;
         c_out        <= 1'b0;
         retired_cnt  <= {CNT_W{1'b0}};
      end else if (freeze) begin
         valid_out    <= valid_out;
         wb_en_out    <= wb_en_out;
         mem_r_en_out <= mem_r_en_out;
         mem_w_en_out <= mem_w_en_out;
         alu_res_out  <= alu_res_out;
         st_val_out   <= st_val_out;
         dest_out     <= dest_out;
         status_reg   <= status_reg;
         c_out        <= c_out;
         retired_cnt  <= retired_cnt;
      end else begin
         // Datapath fields are captured every cycle. They are don't-care in a bubble.
         alu_res_out  <= alu_res_in;
         st_val_out   <= st_val_in;
         dest_out     <= dest_in;
         valid_out    <= accept_s;
         wb_en_out    <= wb_en_in & accept_s;
         // A simultaneous load and store is illegal. Both bits are passed through unchanged.
         mem_r_en_out <= mem_r_en_in & accept_s;
         mem_w_en_out <= mem_w_en_in & accept_s;
         status_reg   <= status_next_s;
         // c_out is a separate copy of the carry flop. It always equals status_reg[1].
         c_out        <= status_next_s[1];
         if (accept_s) begin
            retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            retired_cnt <= retired_cnt;
         end
      end
   end

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_stage_reg
//
// Self-checking bench for exe_mem_stage_reg. The counter is built with
// CNT_W=4 so that the wrap from 15 to 0 can be reached quickly. Expected
// values come from a behavioural model of the stage written in plain terms:
// flags are kept as named N/Z/C/V bits and the counter as an integer
// taken modulo 16.
// ---------------------------------------------------------------------------
module tb_exe_mem_stage_reg;

   localparam int DW    = 32;
   localparam int RW    = 4;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             freeze;
   logic             kill;
   logic             valid_in;
   logic             wb_en_in;
   logic             mem_r_en_in;
   logic             mem_w_en_in;
   logic             s_in;
   logic             cv_upd_in;
   logic [DW-1:0]    alu_res_in;
   logic [3:0]       sr_in;
   logic [DW-1:0]    st_val_in;
   logic [RW-1:0]    dest_in;
   logic             valid_out;
   logic             wb_en_out;
   logic             mem_r_en_out;
   logic             mem_w_en_out;
   logic [DW-1:0]    alu_res_out;
   logic [DW-1:0]    st_val_out;
   logic [RW-1:0]    dest_out;
   logic [3:0]       status_reg;
   logic             c_out;
   logic [CNT_W-1:0] retired_cnt;

   int checks;
   int failures;

   // Reference model state
   bit       m_valid, m_wb, m_rd, m_wr;
   bit [31:0] m_res, m_st;
   bit [3:0] m_dest;
   bit       m_n, m_z, m_c, m_v;
   int       m_cnt;

   exe_mem_stage_reg #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .kill(kill), .valid_in(valid_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .s_in(s_in), .cv_upd_in(cv_upd_in), .alu_res_in(alu_res_in), .sr_in(sr_in),
      .st_val_in(st_val_in), .dest_in(dest_in), .valid_out(valid_out),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .alu_res_out(alu_res_out), .st_val_out(st_val_out), .dest_out(dest_out),
      .status_reg(status_reg), .c_out(c_out), .retired_cnt(retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The model's view of what the stage should hold after the edge just taken.
   task automatic model_edge();
      if (rst) begin
         m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0;
         m_res = 0; m_st = 0; m_dest = 0;
         m_n = 0; m_z = 0; m_c = 0; m_v = 0;
         m_cnt = 0;
      end else if (!freeze) begin
         bit takes;
         takes   = valid_in && !kill;
         m_valid = takes;
         m_wb    = takes && wb_en_in;
         m_rd    = takes && mem_r_en_in;
         m_wr    = takes && mem_w_en_in;
         m_res   = alu_res_in;
         m_st    = st_val_in;
         m_dest  = dest_in;
         if (takes && s_in) begin
            m_n = sr_in[3];
            m_z = sr_in[2];
            if (cv_upd_in) begin
               m_c = sr_in[1];
               m_v = sr_in[0];
            end
         end
         if (takes) m_cnt = (m_cnt + 1) % 16;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, {63'd0, valid_out}, {63'd0, m_valid});
      chk({tag, ".wb"}, {63'd0, wb_en_out}, {63'd0, m_wb});
      chk({tag, ".rd"}, {63'd0, mem_r_en_out}, {63'd0, m_rd});
      chk({tag, ".wr"}, {63'd0, mem_w_en_out}, {63'd0, m_wr});
      chk({tag, ".res"}, {32'd0, alu_res_out}, {32'd0, m_res});
      chk({tag, ".st"}, {32'd0, st_val_out}, {32'd0, m_st});
      chk({tag, ".dest"}, {60'd0, dest_out}, {60'd0, m_dest});
      chk({tag, ".sr"}, {60'd0, status_reg}, {60'd0, m_n, m_z, m_c, m_v});
      chk({tag, ".c"}, {63'd0, c_out}, {63'd0, m_c});
      chk({tag, ".cnt"}, {60'd0, retired_cnt}, 64'(m_cnt));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      rst = 1'b0; freeze = 1'b0; kill = 1'b0; valid_in = 1'b0;
      wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
      s_in = 1'b0; cv_upd_in = 1'b0; alu_res_in = 32'd0; sr_in = 4'd0;
      st_val_in = 32'd0; dest_in = 4'd0;
   endtask

   task automatic randomize_inputs();
      valid_in    = 1'($urandom);
      wb_en_in    = 1'($urandom);
      mem_r_en_in = 1'($urandom);
      mem_w_en_in = 1'($urandom);
      s_in        = 1'($urandom);
      cv_upd_in   = 1'($urandom);
      alu_res_in  = $urandom;
      st_val_in   = $urandom;
      sr_in       = 4'($urandom);
      dest_in     = 4'($urandom);
   endtask

   initial begin
      logic [3:0]  snap_sr;
      logic [3:0]  snap_cnt;
      logic [31:0] snap_res;
      checks = 0;
      failures = 0;
      idle();

      // 1: reset held two cycles under freeze with valid asserted
      rst = 1'b1; freeze = 1'b1; valid_in = 1'b1; wb_en_in = 1'b1;
      alu_res_in = 32'hDEAD_BEEF;
      tick("reset1");
      tick("reset2");
      chk("reset_cnt_zero", {60'd0, retired_cnt}, 64'd0);
      chk("reset_sr_zero", {60'd0, status_reg}, 64'd0);

      // 2: ADDS with flags 0110
      idle();
      valid_in = 1'b1; s_in = 1'b1; cv_upd_in = 1'b1; sr_in = 4'b0110; wb_en_in = 1'b1;
      tick("adds");
      chk("adds_sr", {60'd0, status_reg}, 64'h6);
      chk("adds_c", {63'd0, c_out}, 64'd1);
      chk("adds_cnt", {60'd0, retired_cnt}, 64'd1);

      // 3a: non-S instruction leaves flags alone
      s_in = 1'b0; cv_upd_in = 1'b0; sr_in = 4'b1000;
      tick("no_s");
      chk("no_s_sr", {60'd0, status_reg}, 64'h6);

      // 3b: MOVS keeps C and V
      s_in = 1'b1; cv_upd_in = 1'b0; sr_in = 4'b1000;
      tick("movs");
      chk("movs_sr", {60'd0, status_reg}, 64'hA);

      // 4: killed instruction is a bubble
      kill = 1'b1; wb_en_in = 1'b1; s_in = 1'b1; cv_upd_in = 1'b1; sr_in = 4'b1111;
      mem_w_en_in = 1'b1;
      tick("kill");
      chk("kill_valid", {63'd0, valid_out}, 64'd0);
      chk("kill_sr", {60'd0, status_reg}, 64'hA);
      chk("kill_cnt", {60'd0, retired_cnt}, 64'd3);

      // 5: a load held by freeze for three cycles
      idle();
      valid_in = 1'b1; mem_r_en_in = 1'b1; wb_en_in = 1'b1; alu_res_in = 32'h0000_1000;
      dest_in = 4'd7;
      tick("load");
      snap_sr = status_reg; snap_cnt = retired_cnt; snap_res = alu_res_out;
      for (int i = 0; i < 3; i++) begin
         freeze = 1'b1;
         randomize_inputs();
         kill = 1'($urandom);
         tick("freeze");
         chk("freeze_res_held", {32'd0, alu_res_out}, 64'h1000);
         chk("freeze_sr_held", {60'd0, status_reg}, {60'd0, snap_sr});
         chk("freeze_cnt_held", {60'd0, retired_cnt}, {60'd0, snap_cnt});
      end
      idle();
      valid_in = 1'b1; alu_res_in = 32'h0000_2000;
      tick("release");
      chk("release_res", {32'd0, alu_res_out}, 64'h2000);

      // 6: counter wraps 15 -> 0
      idle();
      valid_in = 1'b1;
      for (int i = 0; i < 40 && m_cnt != 15; i++) tick("fill");
      chk("wrap_pre", {60'd0, retired_cnt}, 64'd15);
      tick("wrap");
      chk("wrap_zero", {60'd0, retired_cnt}, 64'd0);

      // Reset while frozen with state present
      rst = 1'b1; freeze = 1'b1;
      tick("rst_in_freeze");
      rst = 1'b0; freeze = 1'b0; valid_in = 1'b0;
      tick("post_rst_bubble");

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         freeze = ($urandom_range(0, 5) == 0);
         kill   = ($urandom_range(0, 4) == 0);
         rst    = ($urandom_range(0, 60) == 0);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
